// File: rtl/processor_dct_packer.sv
// DCT frame packer: shifts 2-bit trace symbols into a frame buffer and hands
// full or flushed frames to the trace sink over a valid/ready handshake.
module processor_dct_packer #(
    parameter int SYM_W = 2,
    parameter int DEPTH = 15,
    parameter int BUF_W = SYM_W * DEPTH,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sym_valid,
    input  logic [SYM_W-1:0] sym_data,
    output logic             sym_ready,
    input  logic             flush,
    input  logic             end_req,
    output logic [BUF_W-1:0] dct_buffer,
    output logic [CNT_W-1:0] dct_count,
    output logic             frame_valid,
    input  logic             frame_ready,
    output logic             test_ending,
    output logic             test_has_ended
);

    typedef enum logic [1:0] {FILL, EMIT, DONE} state_t;

    state_t           state, state_nxt;
    logic             accept;
    logic [BUF_W-1:0] buf_acc, buf_nxt;
    logic [CNT_W-1:0] cnt_acc, cnt_nxt;
    logic             fv_nxt, te_nxt, the_nxt;

    assign sym_ready = (state == FILL);
    assign accept    = sym_valid && sym_ready;

    // buf_acc/cnt_acc are the post-accept view, so a symbol arriving with
    // flush or end_req lands in the emitted frame.
    always_comb begin
        buf_acc   = accept ? {dct_buffer[BUF_W-SYM_W-1:0], sym_data} : dct_buffer;
        cnt_acc   = accept ? dct_count + CNT_W'(1) : dct_count;
        state_nxt = state;
        buf_nxt   = dct_buffer;
        cnt_nxt   = dct_count;
        fv_nxt    = frame_valid;
        te_nxt    = test_ending;
        the_nxt   = test_has_ended;
        case (state)
            FILL: begin
                buf_nxt = buf_acc;
                cnt_nxt = cnt_acc;
                if (end_req) begin
                    te_nxt = 1'b1;
                    if (cnt_acc != '0) begin
                        state_nxt = EMIT;
                        fv_nxt    = 1'b1;
                    end else begin
                        state_nxt = DONE;
                        the_nxt   = 1'b1;
                    end
                end else if (cnt_acc == CNT_W'(DEPTH) || (flush && cnt_acc != '0)) begin
                    state_nxt = EMIT;
                    fv_nxt    = 1'b1;
                end
            end
            EMIT: begin
                if (end_req) te_nxt = 1'b1;
                if (frame_ready) begin
                    buf_nxt = '0;
                    cnt_nxt = '0;
                    fv_nxt  = 1'b0;
                    if (test_ending || end_req) begin
                        state_nxt = DONE;
                        the_nxt   = 1'b1;
                    end else begin
                        state_nxt = FILL;
                    end
                end
            end
            DONE: ;
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= FILL;
            dct_buffer     <= '0;
            dct_count      <= '0;
            frame_valid    <= 1'b0;
            test_ending    <= 1'b0;
            test_has_ended <= 1'b0;
        end else begin
            state          <= state_nxt;
            dct_buffer     <= buf_nxt;
            dct_count      <= cnt_nxt;
            frame_valid    <= fv_nxt;
            test_ending    <= te_nxt;
            test_has_ended <= the_nxt;
        end
    end

endmodule

// File: tb/tb_processor_dct_packer.sv
// Self-checking bench for processor_dct_packer: directed scenarios plus a
// randomized run against a symbol-list reference model.
module tb_processor_dct_packer;

    logic        clk = 1'b0;
    logic        reset, sym_valid, flush, end_req, frame_ready;
    logic [1:0]  sym_data;
    logic        sym_ready, frame_valid, test_ending, test_has_ended;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    processor_dct_packer dut (
        .clk(clk), .reset(reset), .sym_valid(sym_valid), .sym_data(sym_data),
        .sym_ready(sym_ready), .flush(flush), .end_req(end_req),
        .dct_buffer(dct_buffer), .dct_count(dct_count), .frame_valid(frame_valid),
        .frame_ready(frame_ready), .test_ending(test_ending),
        .test_has_ended(test_has_ended)
    );

    // Frame value as the spec defines it: oldest symbol in the top, newest in [1:0].
    function automatic logic [29:0] pack(input logic [1:0] syms[$]);
        logic [29:0] v = '0;
        foreach (syms[i]) v = v * 4 + 30'(syms[i]);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        sym_valid = 0; sym_data = 0; flush = 0; end_req = 0; frame_ready = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        tick(); tick();
        reset = 0;
    endtask

    task automatic feed(input logic [1:0] s, input logic with_end);
        sym_valid = 1; sym_data = s; end_req = with_end;
        tick();
        sym_valid = 0; end_req = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({frame_valid, test_ending, test_has_ended, sym_ready} !== 4'b0001 ||
            dct_count !== 4'd0 || dct_buffer !== 30'd0) begin
            n_bad++;
            $display("FAIL reset: fv=%b te=%b the=%b rdy=%b cnt=%0d buf=%h, need 0 0 0 1 0 0",
                     frame_valid, test_ending, test_has_ended, sym_ready, dct_count, dct_buffer);
        end
    endtask

    task automatic test_full_frame_backpressure();
        logic [1:0] q[$];
        do_reset();
        for (int i = 0; i < 15; i++) begin
            n_cmp++;
            if (frame_valid !== 1'b0 || sym_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL full_pre%0d: fv=%b rdy=%b, need 0 1", i, frame_valid, sym_ready);
            end
            q.push_back(2'(i % 4));
            feed(2'(i % 4), 1'b0);
        end
        for (int c = 0; c < 6; c++) begin
            n_cmp++;
            if (frame_valid !== 1'b1 || dct_count !== 4'd15 || dct_buffer !== 30'h06C6C6C6 ||
                dct_buffer !== pack(q) || sym_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL full_hold%0d: fv=%b cnt=%0d buf=%h rdy=%b, need 1 15 06c6c6c6 0",
                         c, frame_valid, dct_count, dct_buffer, sym_ready);
            end
            sym_valid = 1; sym_data = 2'd3; flush = 1;
            tick();
        end
        sym_valid = 0; flush = 0;
        frame_ready = 1;
        tick();
        frame_ready = 0;
        n_cmp++;
        if (frame_valid !== 1'b0 || dct_count !== 4'd0 || dct_buffer !== 30'd0 || sym_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL full_after: fv=%b cnt=%0d buf=%h rdy=%b, need 0 0 0 1",
                     frame_valid, dct_count, dct_buffer, sym_ready);
        end
    endtask

    task automatic test_flush();
        do_reset();
        feed(2'd3, 0); feed(2'd3, 0); feed(2'd1, 0);
        flush = 1;
        tick();
        flush = 0;
        n_cmp++;
        if (frame_valid !== 1'b1 || dct_count !== 4'd3 || dct_buffer !== 30'h3D) begin
            n_bad++;
            $display("FAIL flush_frame: fv=%b cnt=%0d buf=%h, need 1 3 3d", frame_valid, dct_count, dct_buffer);
        end
        frame_ready = 1;
        tick();
        frame_ready = 0;
        flush = 1;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++;
            if (frame_valid !== 1'b0 || dct_count !== 4'd0 || sym_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL flush_empty%0d: fv=%b cnt=%0d rdy=%b, need 0 0 1", c, frame_valid, dct_count, sym_ready);
            end
        end
        flush = 0;
    endtask

    task automatic test_end_with_symbol();
        do_reset();
        feed(2'd1, 0); feed(2'd2, 0); feed(2'd3, 0); feed(2'd0, 1);
        n_cmp++;
        if (test_ending !== 1'b1 || test_has_ended !== 1'b0 || frame_valid !== 1'b1 ||
            dct_count !== 4'd4 || dct_buffer !== 30'h6C) begin
            n_bad++;
            $display("FAIL end_sym_frame: te=%b the=%b fv=%b cnt=%0d buf=%h, need 1 0 1 4 6c",
                     test_ending, test_has_ended, frame_valid, dct_count, dct_buffer);
        end
        frame_ready = 1;
        tick();
        frame_ready = 0;
        n_cmp++;
        if (test_has_ended !== 1'b1 || frame_valid !== 1'b0 || sym_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL end_sym_done: the=%b fv=%b rdy=%b, need 1 0 0", test_has_ended, frame_valid, sym_ready);
        end
        sym_valid = 1; flush = 1; end_req = 1;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++;
            if (sym_ready !== 1'b0 || frame_valid !== 1'b0 || dct_count !== 4'd0 ||
                test_ending !== 1'b1 || test_has_ended !== 1'b1) begin
                n_bad++;
                $display("FAIL end_sym_hold%0d: rdy=%b fv=%b cnt=%0d te=%b the=%b, need 0 0 0 1 1",
                         c, sym_ready, frame_valid, dct_count, test_ending, test_has_ended);
            end
        end
        idle_inputs();
    endtask

    task automatic test_end_empty();
        do_reset();
        end_req = 1;
        tick();
        end_req = 0;
        n_cmp++;
        if (test_ending !== 1'b1 || test_has_ended !== 1'b1 || frame_valid !== 1'b0 || sym_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL end_empty: te=%b the=%b fv=%b rdy=%b, need 1 1 0 0",
                     test_ending, test_has_ended, frame_valid, sym_ready);
        end
    endtask

    task automatic test_reset_mid_emit();
        do_reset();
        for (int i = 0; i < 15; i++) feed(2'(i), 0);
        end_req = 1;
        tick();
        end_req = 0;
        n_cmp++;
        if (frame_valid !== 1'b1 || test_ending !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_emit_pre: fv=%b te=%b, need 1 1", frame_valid, test_ending);
        end
        reset = 1;
        tick();
        reset = 0;
        n_cmp++;
        if (frame_valid !== 1'b0 || dct_count !== 4'd0 || dct_buffer !== 30'd0 || sym_ready !== 1'b1 ||
            test_ending !== 1'b0 || test_has_ended !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_emit: fv=%b cnt=%0d buf=%h rdy=%b te=%b the=%b, need 0 0 0 1 0 0",
                     frame_valid, dct_count, dct_buffer, sym_ready, test_ending, test_has_ended);
        end
    endtask

    // Model: a list of symbols collected since the last frame and the frame
    // currently offered to the sink (if any).
    task automatic test_random();
        logic [1:0] q[$];
        logic [1:0] frame[$];
        logic       pending = 0;
        int         frames = 0;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            n_cmp++;
            if (sym_ready !== !pending || frame_valid !== pending ||
                (pending && (dct_count !== 4'(frame.size()) || dct_buffer !== pack(frame))) ||
                (!pending && dct_count !== 4'(q.size()))) begin
                n_bad++;
                $display("FAIL rand_c%0d: rdy=%b fv=%b cnt=%0d buf=%h, need rdy=%b fv=%b cnt=%0d buf=%h",
                         c, sym_ready, frame_valid, dct_count, dct_buffer, !pending, pending,
                         pending ? frame.size() : q.size(), pending ? pack(frame) : pack(q));
            end
            sym_valid   = ($urandom_range(0, 3) != 0);
            sym_data    = 2'($urandom);
            flush       = ($urandom_range(0, 9) == 0);
            frame_ready = ($urandom_range(0, 2) == 0);
            if (!pending) begin
                if (sym_valid) q.push_back(sym_data);
                if (q.size() == 15 || (flush && q.size() > 0)) begin
                    frame = q;
                    q.delete();
                    pending = 1;
                    frames++;
                end
            end else if (frame_ready) begin
                pending = 0;
            end
            tick();
        end
        idle_inputs();
        n_cmp++;
        if (frames < 10) begin
            n_bad++;
            $display("FAIL rand_frames: saw %0d frames, need at least 10", frames);
        end
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        test_reset();
        test_full_frame_backpressure();
        test_flush();
        test_end_with_symbol();
        test_end_empty();
        test_reset_mid_emit();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/processor_dct_packer.md
# processor_dct_packer

Producer side of the OCI data-compression-trace (DCT) frame interface. It accepts 2-bit trace symbols from the debug core and packs them into a 30-bit frame buffer with a 4-bit fill count. It presents each frame to the trace sink through a valid/ready handshake, and drives the end-of-test indications consumed by the OCI test bench.

## Interface
Parameters:
- SYM_W, 2, width of one trace symbol in bits.
- DEPTH, 15, symbols per full frame.
- BUF_W, 30, frame width; fixed at SYM_W*DEPTH.
- CNT_W, 4, fill-count width; must hold DEPTH.

Ports:
- clk  in  1  sole clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- sym_valid  in  1  a trace symbol is offered.
- sym_data  in  SYM_W  trace symbol.
- sym_ready  out  1  packer accepts a symbol this cycle.
- flush  in  1  request to emit a partial frame.
- end_req  in  1  end-of-test request; a one-cycle pulse is sufficient.
- dct_buffer  out  BUF_W  packed frame; newest symbol in bits [1:0].
- dct_count  out  CNT_W  number of valid symbols in dct_buffer.
- frame_valid  out  1  frame is presented to the sink.
- frame_ready  in  1  sink takes the frame.
- test_ending  out  1  end of test requested; sticky.
- test_has_ended  out  1  final frame drained; sticky.

## Operation
- States: FILL, EMIT, DONE. All outputs are registered, except sym_ready, which is decoded as (state==FILL).
- Reset values: state=FILL, dct_buffer=0, dct_count=0, frame_valid=0, test_ending=0, test_has_ended=0.
- FILL, accept condition: a symbol is accepted when sym_valid && sym_ready.
  - On accept: dct_buffer <= {dct_buffer[BUF_W-SYM_W-1:0], sym_data} and dct_count <= dct_count+1.
  - If the post-accept count equals DEPTH: go to EMIT.
- FILL, flush: flush with a post-accept count > 0 goes to EMIT with a partial frame.
  - flush with a count of 0 is ignored and no frame is produced.
- FILL, end_req:
  - Set test_ending.
  - If the post-accept count is > 0: go to EMIT.
  - Otherwise: go to DONE.
- Simultaneous accept with flush or end_req: the symbol is accepted first and is included in the emitted frame.
- EMIT:
  - frame_valid=1; sym_ready=0.
  - dct_buffer and dct_count are held stable until the handshake.
  - On frame_valid && frame_ready: clear dct_buffer and dct_count to 0 and drop frame_valid. Next state is DONE if test_ending is set, otherwise FILL.
  - end_req during EMIT sets test_ending; the current frame completes and the state then goes to DONE.
  - flush during EMIT is ignored.
- DONE:
  - test_has_ended=1 and sym_ready=0.
  - Further flush and end_req are ignored.
  - The state holds until reset.
- Overflow cannot occur, because the count never exceeds DEPTH. dct_count=0 is never presented with frame_valid=1.

## Timing
- The symbol that completes the frame is accepted in cycle N. In N+1, frame_valid=1 and dct_count=15.
- Minimum time from one full frame to the next FILL accept is 1 cycle after the handshake. sym_ready rises in the cycle after frame_ready is sampled high.
- flush sampled high in cycle N with count > 0: frame_valid=1 in N+1.
- end_req sampled in cycle N: test_ending=1 in N+1.
  - With an empty buffer: test_has_ended=1 in N+1.
  - Otherwise: test_has_ended=1 in the cycle after the final frame handshake.
- reset asserted in any state, including mid-EMIT with frame_valid=1: all outputs return to their reset values in the next cycle. The pending frame is discarded.
- Both handshakes are combinational to the edge: a transfer occurs on any edge where valid and ready are both 1. There is no wait state on the input side.

## Test plan
- Feed 15 symbols 0,1,2,3,0,1,… back to back -> frame_valid in cycle 16. dct_count=15 and dct_buffer=30'h06C6C6C6 (newest symbol in [1:0]). sym_ready=0 while in EMIT.
- Full frame with frame_ready held low for 5 cycles -> dct_buffer/dct_count stable and frame_valid=1 throughout. After the handshake, count=0 and sym_ready=1 in the next cycle.
- 3 symbols (3,3,1), then flush -> frame with dct_count=3 and dct_buffer=30'h3D. A later flush with an empty buffer produces no frame_valid.
- end_req in the same cycle as a 4th accepted symbol -> test_ending next cycle and a frame with count=4. test_has_ended=1 the cycle after the handshake; sym_ready stays 0 thereafter.
- end_req with an empty buffer -> test_ending and test_has_ended both 1 one cycle later, with no frame emitted.
- reset pulse mid-EMIT -> next cycle frame_valid=0, dct_count=0, dct_buffer=0, sym_ready=1. Test flags are cleared.
